irq_pending_ctrl: RTL and testbench

//  Collects one-clock rising-edge pulses from the edge finder stages into sticky

---
 rtl/irq_pending_ctrl.sv | 149 ++++++++++++++
 tb/tb_irq_pending_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
//   Captures one-clock pulses from upstream edge finders into sticky pending
//   bits, gates them with a software enable mask and drives registered level
//   interrupt lines. Register access is through a 4-word mem-bus slave.
//
//   Ports:
//     clk, reset        system clock, asynchronous active-high reset
//     pulse_in          one-clock pulses, one per source
//     sel/addr/wstrb/   bus request (addr is word address, wstrb==0 reads);
//     wdata             sel is held by the master until ready
//     rdata/ready       read data and one-cycle acknowledge (rdata=0 when idle)
//     irq_out           pending & enable per source, registered
//     irq_any           OR of irq_out, registered
//
//   Register map (word address):
//     0 PENDING  read; write-1-to-clear
//     1 ENABLE   read/write, byte strobed
//     2 STATUS   read-only, pending & enable
//     3 FORCE    write-1-to-set pending; reads 0
module irq_pending_ctrl #(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] pulse_in,
    input  logic               sel,
    input  logic [1:0]         addr,
    input  logic [3:0]         wstrb,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [NUM_SRC-1:0] irq_out,
    output logic               irq_any
);

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_FORCE   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  pending_nxt;
    logic [NUM_SRC-1:0]  enable;
    logic [NUM_SRC-1:0]  enable_nxt;
    logic [NUM_SRC-1:0]  irq_nxt;
    logic                ready_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic [NUM_SRC-1:0]  w1c_bits;
    logic [NUM_SRC-1:0]  w1s_bits;

    logic [DATA_W-1:0]   byte_mask;
    logic [DATA_W-1:0]   wdata_masked;
    logic [NUM_SRC-1:0]  wr_bits;
    logic [DATA_W-1:0]   rd_mux;
    logic                wr_en;
    logic                unused_wdata;

    // Expand byte strobes to a bit mask; only bits backed by a source are kept
    assign byte_mask    = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign wdata_masked = wdata & byte_mask;
    assign wr_bits      = wdata_masked[NUM_SRC-1:0];
    assign wr_en        = |wstrb;

    // Data bits above NUM_SRC have no register behind them
    assign unused_wdata = ^wdata_masked;

    // Read mux, sampled from pre-write register state
    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_PENDING: rd_mux = DATA_W'(pending);
            ADDR_ENABLE:  rd_mux = DATA_W'(enable);
            ADDR_STATUS:  rd_mux = DATA_W'(pending & enable);
            ADDR_FORCE:   rd_mux = '0;
            default:      rd_mux = '0;
        endcase
    end

    // Bus FSM next state, register writes and next-state interrupt view
    always_comb begin
        state_nxt  = state;
        ready_nxt  = 1'b0;
        rdata_nxt  = '0;
        enable_nxt = enable;
        w1c_bits   = '0;
        w1s_bits   = '0;

        case (state)
            ST_IDLE: begin
                if (sel) begin
                    state_nxt = ST_ACK;
                    ready_nxt = 1'b1;
                    rdata_nxt = rd_mux;
                    if (wr_en) begin
                        case (addr)
                            ADDR_PENDING: w1c_bits   = wr_bits;
                            ADDR_ENABLE:  enable_nxt = (enable & ~NUM_SRC'(byte_mask))
                                                     | wr_bits;
                            ADDR_FORCE:   w1s_bits   = wr_bits;
                            default:      ;
                        endcase
                    end
                end
            end
            ST_ACK: begin
                // Master drops sel after ready, so always return to idle
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A pulse in the same cycle as a clear of that bit keeps it set
        pending_nxt = (pending & ~w1c_bits) | w1s_bits | pulse_in;
        irq_nxt     = pending_nxt & enable_nxt;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            pending <= '0;
            enable  <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
            irq_out <= '0;
            irq_any <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            enable  <= enable_nxt;
            ready   <= ready_nxt;
            rdata   <= rdata_nxt;
            irq_out <= irq_nxt;
            irq_any <= |irq_nxt;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl: each bus access pushes its expected
// read data; a negedge monitor pops and compares whenever ready is high.
module tb_irq_pending_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pulse_in;
    logic        sel;
    logic [1:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [7:0]  irq_out;
    logic        irq_any;

    logic [31:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    irq_pending_ctrl #(.NUM_SRC(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .sel      (sel),
        .addr     (addr),
        .wstrb    (wstrb),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .irq_out  (irq_out),
        .irq_any  (irq_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare rdata against the scoreboard on every acknowledge
    always @(negedge clk) begin
        if (!reset) begin
            if (ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ready: rdata 0x%08h with no access outstanding", rdata);
                end else begin
                    check("rdata", rdata, exp_q.pop_front());
                end
            end else begin
                check("rdata_idle", rdata, 32'h0);
            end
        end
    end

    // One bus access with optional simultaneous pulse; exp_rd is pre-write read data
    task automatic bus(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic [7:0] p);
        @(negedge clk);
        sel      = 1'b1;
        addr     = a;
        wstrb    = s;
        wdata    = d;
        pulse_in = p;
        exp_q.push_back(exp_rd);
        @(negedge clk);
        check("ready_ack", 32'(ready), 32'h1);
        sel      = 1'b0;
        wstrb    = 4'h0;
        pulse_in = 8'h00;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp_rd);
        bus(a, 4'h0, 32'h0, exp_rd, 8'h00);
    endtask

    task automatic pulse(input logic [7:0] p);
        @(negedge clk);
        pulse_in = p;
        @(negedge clk);
        pulse_in = 8'h00;
    endtask

    task automatic check_irq(input string name, input logic [7:0] exp_irq);
        check({name, "_irq_out"}, 32'(irq_out), 32'(exp_irq));
        check({name, "_irq_any"}, 32'(irq_any), 32'(|exp_irq));
    endtask

    initial begin
        reset    = 1'b1;
        pulse_in = 8'h00;
        sel      = 1'b0;
        addr     = 2'd0;
        wstrb    = 4'h0;
        wdata    = 32'h0;
        #12;
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check_irq("rst", 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Capture with everything masked
        pulse(8'h05);
        check_irq("masked", 8'h00);
        rd(2'd0, 32'h05);
        rd(2'd2, 32'h00);

        // Enable source 2: interrupt right after the write edge
        bus(2'd1, 4'b0001, 32'h04, 32'h00, 8'h00);
        check_irq("en4", 8'h04);
        rd(2'd2, 32'h04);
        rd(2'd1, 32'h04);

        // Clear bit 2 while it pulses again: set wins
        bus(2'd0, 4'b1111, 32'h04, 32'h05, 8'h04);
        rd(2'd0, 32'h05);
        check_irq("w1c_race", 8'h04);

        // Force bit 7; strobe on a byte with no sources leaves ENABLE alone
        bus(2'd3, 4'b1111, 32'h80, 32'h00, 8'h00);
        rd(2'd0, 32'h85);
        check_irq("force", 8'h04);
        bus(2'd1, 4'b0010, 32'hFF, 32'h04, 8'h00);
        rd(2'd1, 32'h04);

        // Plain clear, and strobe on wrong byte does not clear
        bus(2'd0, 4'b0010, 32'h01, 32'h85, 8'h00);
        rd(2'd0, 32'h85);
        bus(2'd0, 4'b1111, 32'h01, 32'h85, 8'h00);
        rd(2'd0, 32'h84);

        // Drop enable: irq falls, pending retained
        bus(2'd1, 4'b0001, 32'h00, 32'h04, 8'h00);
        check_irq("dis", 8'h00);
        rd(2'd0, 32'h84);

        // STATUS is read-only
        bus(2'd2, 4'b1111, 32'hFF, 32'h00, 8'h00);
        rd(2'd2, 32'h00);
        rd(2'd1, 32'h00);

        // Repeated pulse on a pending bit stays one bit
        pulse(8'h80);
        rd(2'd0, 32'h84);

        // Enable bit 7, clear it, then a pulse raises irq after its edge
        bus(2'd1, 4'b0001, 32'h80, 32'h00, 8'h00);
        check_irq("en80", 8'h80);
        bus(2'd0, 4'b0001, 32'h80, 32'h84, 8'h00);
        check_irq("clr80", 8'h00);
        @(negedge clk);
        pulse_in = 8'h80;
        @(negedge clk);
        check_irq("pulse80", 8'h80);
        pulse_in = 8'h00;

        // Hold sel on ENABLE for 4 cycles: ready on cycles 1 and 3
        @(negedge clk);
        sel   = 1'b1;
        addr  = 2'd1;
        wstrb = 4'h0;
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h80);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_ready", 32'(ready), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        sel = 1'b0;

        // Reset while in ACK: everything drops immediately
        @(negedge clk);
        sel  = 1'b1;
        addr = 2'd0;
        @(posedge clk);
        #2;
        check("pre_rst_ready", 32'(ready), 32'h1);
        reset = 1'b1;
        sel   = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check_irq("midrst", 8'h00);
        @(negedge clk);
        reset = 1'b0;
        rd(2'd0, 32'h00);
        rd(2'd1, 32'h00);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
